multicycle_control: RTL and testbench

Parametrised multi-cycle MIPS32 main control unit, the successor to the single-cycle opcode decoder. It is a state machine that sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over several cycles. It drives the shared-ALU datapath mux and enable signals, stalls on a memory-ready handshake, and traps on illegal opcodes or memory timeout. It sits between the instruction register (the Opcode source) and the multi-cycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 47 ++++
 rtl/multicycle_control.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS32 main control unit.
// Contents: FSM state enum, opcode constants, ALUOp codes, ALUSrcB and
// PCSource mux encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StRwb,
        StExecI,
        StIwb,
        StBranch,
        StJump,
        StTrap
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int unsigned ALU_ADD   = 0;
    localparam int unsigned ALU_SUB   = 1;
    localparam int unsigned ALU_FUNCT = 2;
    localparam int unsigned ALU_SLT   = 3;
    localparam int unsigned ALU_AND   = 4;
    localparam int unsigned ALU_OR    = 5;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   waitState   - FSM is in a state that waits on MemReady (FETCH/MEMRD/MEMWR)
//   memReady    - memory handshake
//   timeout     - this stalled cycle is the MEM_TIMEOUT-th in a row (never set if MEM_TIMEOUT = 0)
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waitState,
    input  logic memReady,
    output logic timeout
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = '1;

    logic [CntW-1:0] cntQ, cntD;
    logic            stalled;

    assign stalled = waitState && !memReady;

    // cntQ counts earlier stalled cycles, so cntQ + 1 includes the current one.
    assign timeout = (MEM_TIMEOUT > 0) && stalled && ((32'(cntQ) + 32'd1) >= MEM_TIMEOUT);

    // A wait state is only left on MemReady or on timeout, so clearing on those
    // two (and outside wait states) also covers every state change.
    always_comb begin
        cntD = cntQ;
        if (!stalled || timeout) begin
            cntD = '0;
        end else if (cntQ != CntMax) begin
            cntD = cntQ + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 main control FSM: sequences fetch, decode, execute, memory
// and writeback, driving the shared-ALU datapath muxes and enables.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   Opcode             - instr[31:26] from the IR (sampled in DECODE)
//   MemReady           - memory access completes this cycle
//   PCWrite/PCWriteCond/BranchNe/PCSource - PC update control
//   IorD/MemRead/MemWrite/IRWrite          - memory and IR control
//   MemToReg/RegDst/RegWrite               - register file writeback control
//   ALUSrcA/ALUSrcB/ExtZero/ALUOp          - ALU operand and operation select
//   InstrDone          - pulses in the last cycle of each instruction
//   IllegalOp/MemTimeout - sticky trap causes
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W      = 3,
    parameter bit          EN_BNE       = 1'b1,
    parameter bit          EN_LOGIC_IMM = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtZero,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               InstrDone,
    output logic               IllegalOp,
    output logic               MemTimeout
);

    state_t     stateQ, stateD;
    logic [5:0] opRegQ;
    logic       illegalOpQ, memTimeoutQ;
    logic       illegalDet;
    logic       waitState;
    logic       timeout;

    assign waitState = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .waitState(waitState),
        .memReady (MemReady),
        .timeout  (timeout)
    );

    always_comb begin
        stateD      = stateQ;
        illegalDet  = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ExtZero     = 1'b0;
        ALUOp       = ALUOP_W'(ALU_ADD);
        PCSource    = PCSRC_ALU;
        InstrDone   = 1'b0;

        case (stateQ)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (timeout)       stateD = StTrap;
                else if (MemReady) stateD = StDecode;
            end
            StDecode: begin
                // Branch target PC + (imm << 2) is computed speculatively here.
                ALUSrcB = SRCB_IMM_SH;
                case (Opcode)
                    OP_RTYPE:         stateD = StExecR;
                    OP_LW, OP_SW:     stateD = StMemAdr;
                    OP_ADDI, OP_SLTI: stateD = StExecI;
                    OP_ANDI, OP_ORI:  stateD = EN_LOGIC_IMM ? StExecI : StTrap;
                    OP_BEQ:           stateD = StBranch;
                    OP_BNE:           stateD = EN_BNE ? StBranch : StTrap;
                    OP_J:             stateD = StJump;
                    default:          stateD = StTrap;
                endcase
                illegalDet = (stateD == StTrap);
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                stateD  = (opRegQ == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (timeout)       stateD = StTrap;
                else if (MemReady) stateD = StMemWb;
            end
            StMemWb: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                stateD   = StFetch;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (timeout)       stateD = StTrap;
                else if (MemReady) stateD = StFetch;
            end
            StExecR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALUOP_W'(ALU_FUNCT);
                stateD  = StRwb;
            end
            StRwb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                stateD   = StFetch;
            end
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (opRegQ)
                    OP_SLTI: ALUOp = ALUOP_W'(ALU_SLT);
                    OP_ANDI: begin
                        ALUOp   = ALUOP_W'(ALU_AND);
                        ExtZero = 1'b1;
                    end
                    OP_ORI: begin
                        ALUOp   = ALUOP_W'(ALU_OR);
                        ExtZero = 1'b1;
                    end
                    default: ALUOp = ALUOP_W'(ALU_ADD);
                endcase
                stateD = StIwb;
            end
            StIwb: begin
                RegWrite = 1'b1;
                stateD   = StFetch;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALUOP_W'(ALU_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (opRegQ == OP_BNE);
                stateD      = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                stateD   = StFetch;
            end
            StTrap: stateD = StTrap;
            default: stateD = StFetch;
        endcase

        InstrDone = (stateD == StFetch) && (stateQ != StFetch);

        // Reset state is FETCH, whose outputs are non-zero; force them low
        // for as long as rst_n is held.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            BranchNe    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ExtZero     = 1'b0;
            ALUOp       = '0;
            PCSource    = 2'b00;
            InstrDone   = 1'b0;
        end
    end

    assign IllegalOp  = illegalOpQ;
    assign MemTimeout = memTimeoutQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= StFetch;
            opRegQ      <= '0;
            illegalOpQ  <= 1'b0;
            memTimeoutQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (stateQ == StDecode) opRegQ <= Opcode;
            if (illegalDet)         illegalOpQ <= 1'b1;
            if (timeout)            memTimeoutQ <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. dutA: all opcodes legal, MEM_TIMEOUT = 4.
// dutB: BNE/ANDI/ORI illegal, no timeout. Both share clock, reset and inputs.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branchNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       extZero;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       illegalOp;
        logic       memTimeout;
    } ctl_t;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBad  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;

    logic aPcWrite, aPcWriteCond, aBranchNe, aIorD, aMemRead, aMemWrite, aIrWrite;
    logic aMemToReg, aRegDst, aRegWrite, aAluSrcA, aExtZero, aInstrDone, aIllegalOp, aMemTimeout;
    logic [1:0] aAluSrcB, aPcSource;
    logic [2:0] aAluOp;
    logic bPcWrite, bPcWriteCond, bBranchNe, bIorD, bMemRead, bMemWrite, bIrWrite;
    logic bMemToReg, bRegDst, bRegWrite, bAluSrcA, bExtZero, bInstrDone, bIllegalOp, bMemTimeout;
    logic [1:0] bAluSrcB, bPcSource;
    logic [2:0] bAluOp;

    ctl_t gotA, gotB;
    int   checks = 0;
    int   errors = 0;

    assign gotA = {aPcWrite, aPcWriteCond, aBranchNe, aIorD, aMemRead, aMemWrite, aIrWrite,
                   aMemToReg, aRegDst, aRegWrite, aAluSrcA, aAluSrcB, aExtZero, aAluOp,
                   aPcSource, aInstrDone, aIllegalOp, aMemTimeout};
    assign gotB = {bPcWrite, bPcWriteCond, bBranchNe, bIorD, bMemRead, bMemWrite, bIrWrite,
                   bMemToReg, bRegDst, bRegWrite, bAluSrcA, bAluSrcB, bExtZero, bAluOp,
                   bPcSource, bInstrDone, bIllegalOp, bMemTimeout};

    multicycle_control #(
        .ALUOP_W(3), .EN_BNE(1'b1), .EN_LOGIC_IMM(1'b1), .MEM_TIMEOUT(4)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(aPcWrite), .PCWriteCond(aPcWriteCond), .BranchNe(aBranchNe), .IorD(aIorD),
        .MemRead(aMemRead), .MemWrite(aMemWrite), .IRWrite(aIrWrite), .MemToReg(aMemToReg),
        .RegDst(aRegDst), .RegWrite(aRegWrite), .ALUSrcA(aAluSrcA), .ALUSrcB(aAluSrcB),
        .ExtZero(aExtZero), .ALUOp(aAluOp), .PCSource(aPcSource), .InstrDone(aInstrDone),
        .IllegalOp(aIllegalOp), .MemTimeout(aMemTimeout)
    );

    multicycle_control #(
        .ALUOP_W(3), .EN_BNE(1'b0), .EN_LOGIC_IMM(1'b0), .MEM_TIMEOUT(0)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(bPcWrite), .PCWriteCond(bPcWriteCond), .BranchNe(bBranchNe), .IorD(bIorD),
        .MemRead(bMemRead), .MemWrite(bMemWrite), .IRWrite(bIrWrite), .MemToReg(bMemToReg),
        .RegDst(bRegDst), .RegWrite(bRegWrite), .ALUSrcA(bAluSrcA), .ALUSrcB(bAluSrcB),
        .ExtZero(bExtZero), .ALUOp(bAluOp), .PCSource(bPcSource), .InstrDone(bInstrDone),
        .IllegalOp(bIllegalOp), .MemTimeout(bMemTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control words, written straight from the state descriptions.
    function automatic ctl_t eFetch(input logic mr);
        ctl_t e;
        e = '0; e.memRead = 1'b1; e.aluSrcB = 2'b01; e.irWrite = mr; e.pcWrite = mr;
        return e;
    endfunction
    function automatic ctl_t eDecode();
        ctl_t e;
        e = '0; e.aluSrcB = 2'b11;
        return e;
    endfunction
    function automatic ctl_t eMemAdr();
        ctl_t e;
        e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        return e;
    endfunction
    function automatic ctl_t eMemRd();
        ctl_t e;
        e = '0; e.memRead = 1'b1; e.iorD = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eMemWb();
        ctl_t e;
        e = '0; e.memToReg = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eMemWr(input logic mr);
        ctl_t e;
        e = '0; e.memWrite = 1'b1; e.iorD = 1'b1; e.instrDone = mr;
        return e;
    endfunction
    function automatic ctl_t eExecR();
        ctl_t e;
        e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b00; e.aluOp = 3'd2;
        return e;
    endfunction
    function automatic ctl_t eRwb();
        ctl_t e;
        e = '0; e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eExecIOri();
        ctl_t e;
        e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'd5; e.extZero = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eIwb();
        ctl_t e;
        e = '0; e.regWrite = 1'b1; e.instrDone = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eBranch(input logic ne);
        ctl_t e;
        e = '0; e.aluSrcA = 1'b1; e.aluOp = 3'd1; e.pcWriteCond = 1'b1;
        e.pcSource = 2'b01; e.branchNe = ne; e.instrDone = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eJump();
        ctl_t e;
        e = '0; e.pcWrite = 1'b1; e.pcSource = 2'b10; e.instrDone = 1'b1;
        return e;
    endfunction
    function automatic ctl_t eTrap(input logic ill, input logic tmo);
        ctl_t e;
        e = '0; e.illegalOp = ill; e.memTimeout = tmo;
        return e;
    endfunction

    task automatic chk(input string tag, input ctl_t got, input ctl_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst_n    = rst;
        Opcode   = op;
        MemReady = mr;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = '0;
        MemReady = 1'b0;

        cyc(1'b0, OpLw, 1'b1); chk("rst_a", gotA, '0); chk("rst_b", gotB, '0);

        // LW, MemReady high throughout: F D MA MR MWB
        cyc(1'b1, OpLw, 1'b1); chk("lw_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpLw, 1'b1); chk("lw_decode", gotA, eDecode());
        cyc(1'b1, OpLw, 1'b1); chk("lw_memadr", gotA, eMemAdr());
        cyc(1'b1, OpLw, 1'b1); chk("lw_memrd", gotA, eMemRd());
        cyc(1'b1, OpLw, 1'b1); chk("lw_memwb", gotA, eMemWb());

        // LW interrupted by reset while stalled in MEMRD
        cyc(1'b1, OpLw, 1'b1); chk("lw2_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpLw, 1'b0); chk("lw2_decode", gotA, eDecode());
        cyc(1'b1, OpLw, 1'b0); chk("lw2_memadr", gotA, eMemAdr());
        cyc(1'b1, OpLw, 1'b0); chk("lw2_memrd_wait", gotA, eMemRd());
        cyc(1'b0, OpLw, 1'b0); chk("rst_mid_memrd", gotA, '0);
        cyc(1'b1, OpLw, 1'b0); chk("fetch_after_rst", gotA, eFetch(1'b0));

        // SW with three stalled MEMWR cycles
        cyc(1'b1, OpSw, 1'b1); chk("sw_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpSw, 1'b0); chk("sw_decode", gotA, eDecode());
        cyc(1'b1, OpSw, 1'b0); chk("sw_memadr", gotA, eMemAdr());
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, OpSw, 1'b0); chk("sw_memwr_wait", gotA, eMemWr(1'b0));
        end
        cyc(1'b1, OpSw, 1'b1); chk("sw_memwr_done", gotA, eMemWr(1'b1));

        // R-type
        cyc(1'b1, OpR, 1'b1); chk("r_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpR, 1'b1); chk("r_decode", gotA, eDecode());
        cyc(1'b1, OpR, 1'b1); chk("r_exec", gotA, eExecR());
        cyc(1'b1, OpR, 1'b1); chk("r_wb", gotA, eRwb());

        // BNE: branch on dutA, illegal on dutB
        cyc(1'b1, OpBne, 1'b1); chk("bne_fetch_a", gotA, eFetch(1'b1));
        chk("bne_fetch_b", gotB, eFetch(1'b1));
        cyc(1'b1, OpBne, 1'b1); chk("bne_decode_a", gotA, eDecode());
        chk("bne_decode_b", gotB, eDecode());
        cyc(1'b1, OpBne, 1'b0); chk("bne_branch_a", gotA, eBranch(1'b1));
        chk("bne_trap_b", gotB, eTrap(1'b1, 1'b0));

        // MemReady stuck low: dutA times out after 4 FETCH wait cycles
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, OpJ, 1'b0);
            chk("trap_hold_b", gotB, eTrap(1'b1, 1'b0));
            if (i < 4) chk("tmo_fetch_a", gotA, eFetch(1'b0));
            else       chk("tmo_trap_a", gotA, eTrap(1'b0, 1'b1));
        end

        cyc(1'b0, OpOri, 1'b0); chk("rst2_a", gotA, '0); chk("rst2_b", gotB, '0);

        // ORI, with Opcode changed after DECODE
        cyc(1'b1, OpOri, 1'b1); chk("ori_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpOri, 1'b1); chk("ori_decode", gotA, eDecode());
        cyc(1'b1, OpAddi, 1'b1); chk("ori_exec", gotA, eExecIOri());
        chk("ori_trap_b", gotB, eTrap(1'b1, 1'b0));
        cyc(1'b1, OpAddi, 1'b1); chk("ori_wb", gotA, eIwb());

        // MemReady arrives on the 4th FETCH cycle: no timeout
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, OpJ, 1'b0); chk("late_fetch_wait", gotA, eFetch(1'b0));
        end
        cyc(1'b1, OpJ, 1'b1); chk("late_fetch_ready", gotA, eFetch(1'b1));
        cyc(1'b1, OpJ, 1'b1); chk("late_decode", gotA, eDecode());
        cyc(1'b1, OpJ, 1'b1); chk("j_jump", gotA, eJump());

        // Undefined opcode traps dutA too
        cyc(1'b1, OpBad, 1'b1); chk("bad_fetch", gotA, eFetch(1'b1));
        cyc(1'b1, OpBad, 1'b1); chk("bad_decode", gotA, eDecode());
        cyc(1'b1, OpBad, 1'b1); chk("bad_trap", gotA, eTrap(1'b1, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
